muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the signed multiply and divide operations, ALU control codes 10 (mult) and 11 (div). The single-cycle ALU only decodes these codes; this block runs the iterative shift-add multiply and restoring divide and owns the HI/LO register pair. It sits beside the ALU in the execute stage. The pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, 32, operand width and HI/LO width.
- `CONTROL_LENGTH`, 4, width of the ALU control code.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `control`  in  CONTROL_LENGTH  10 = signed mult, 11 = signed div; any other value with `start` is ignored.
- `a`, `b`  in  WIDTH each  rs and rt operands, two's complement; captured on acceptance.
- `hi_we`, `lo_we`  in  1 each  mthi/mtlo write strobes; honoured only in IDLE.
- `wdata`  in  WIDTH  data for mthi/mtlo.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; the result is visible on `hi`/`lo` in the same cycle.
- `div_by_zero`  out  1  valid with `done`; set for a div with `b`==0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- States:
  - IDLE: waits for a request.
  - ITER: one quotient or product bit per cycle, with a down-counter of WIDTH.
  - FIX: sign correction and HI/LO write.
- Acceptance, IDLE: `start` with `control` equal to 10 or 11.
  - The block stores the magnitudes |a| and |b|, the result sign, the remainder sign (the sign of `a`) and the op type.
  - It then goes to ITER.
- Mult:
  - Unsigned shift-add over 2*WIDTH bits, LSB first.
  - In FIX the product is negated if the operand signs differ.
  - {hi,lo} receive the 2*WIDTH-bit signed product.
- Div:
  - Restoring division, MSB first.
  - Quotient truncates toward zero and goes to `lo`.
  - Remainder takes the sign of the dividend and goes to `hi`.
  - The case -2^(WIDTH-1) / -1 gives `lo` = 0x80000000 and `hi` = 0; there is no trap.
- Div with `b`==0:
  - The block goes straight from IDLE to FIX and skips ITER.
  - Result: `hi` = `a`, `lo` = all ones, `div_by_zero` = 1.
- Magnitude arithmetic is done at WIDTH+1 bits so that |-2^(WIDTH-1)| is represented exactly.
- mthi/mtlo:
  - In IDLE, `hi_we` loads `hi` from `wdata` and `lo_we` loads `lo` from `wdata`. Both may be written in the same cycle.
  - Writes outside IDLE are dropped.
- Conflict: `start` accepted in the same cycle as `hi_we`/`lo_we` means `start` wins and the write is dropped.
- `hi` and `lo` hold their values between completions and writes.

## Timing
- Reset, asynchronous and taking effect immediately, with no wait for a clock edge:
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `hi`, `lo` = 0.
- A reset asserted mid-operation aborts the operation. No `done` pulse is produced and HI/LO are cleared.
- Edge E0 accepts the request and `busy` rises after E0.
- Normal op:
  - Edges E1..E_WIDTH perform the iterations.
  - Edge E_(WIDTH+1) executes FIX: HI/LO are written, `busy` falls and `done` rises.
  - Latency from the accepting edge to `done` is WIDTH+1 cycles, i.e. 33 at default.
- Div by zero: FIX runs at E1, so `done` is high after E1, one cycle after acceptance.
- `done` and `div_by_zero` are high for exactly one cycle, then return to 0.
- `start` while `busy` is ignored and is not queued.
- A new `start` in the `done` cycle is accepted, because the block is already in IDLE. Back-to-back operations are therefore legal with no idle gap.
- `busy` is a registered output. There is no combinational path from `start` to `busy`.

## Test plan
- mult `a`=7, `b`=0xFFFFFFFD (-3) -> `busy` high for 33 cycles, `done` at cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- div `a`=0xFFFFFFF9 (-7), `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- div `a`=5, `b`=0 -> `done` and `div_by_zero` high 1 cycle after acceptance, `hi`=5, `lo`=0xFFFFFFFF.
- mult 0x7FFFFFFF * 0x7FFFFFFF with a second `start` (div 9/3) at cycle 10 -> the second request is ignored. Result `hi`=0x3FFFFFFF, `lo`=0x00000001, with exactly one `done`.
- `hi_we` `wdata`=0x1234 in IDLE -> `hi`=0x1234. A `lo_we` during `busy` is dropped. `start` together with `lo_we` -> the op runs and the write is dropped.
- mult in progress, `rst_n` low at cycle 15 -> all outputs 0 immediately. No `done` after release, and a fresh op completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / divide unit that owns the
// architectural HI/LO pair. One product or quotient bit is produced per
// cycle. The pipeline stalls on busy.
module muldiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int CONTROL_LENGTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CONTROL_LENGTH-1:0] control,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      hi_we,
  input  logic                      lo_we,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero,
  output logic [WIDTH-1:0]          hi,
  output logic [WIDTH-1:0]          lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CONTROL_LENGTH-1:0] CTRL_MULT = CONTROL_LENGTH'(10);
  localparam logic [CONTROL_LENGTH-1:0] CTRL_DIV  = CONTROL_LENGTH'(11);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  // Magnitude of a two's complement value, one bit wider so that the most
  // negative operand is represented exactly.
  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH:0] e;
    e = {x[WIDTH-1], x};
    return x[WIDTH-1] ? (~e + {{WIDTH{1'b0}}, 1'b1}) : e;
  endfunction

  // Two's complement negation, single width.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation, double width (full product).
  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state, state_nx;
  logic             accept;
  logic [CNT_W-1:0] cnt;

  // Working register: upper WIDTH+1 bits hold the partial product / partial
  // remainder, lower WIDTH bits hold the multiplier / dividend-then-quotient.
  logic [2*WIDTH:0] p;
  logic [2*WIDTH:0] p_step;
  logic [WIDTH:0]   opnd;
  logic             is_div;
  logic             div_zero_q;
  logic             res_neg;
  logic             rem_neg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; a div by zero bypasses the iterations entirely.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (control == CTRL_MULT || control == CTRL_DIV)) begin
          accept   = 1'b1;
          state_nx = (control == CTRL_DIV && b == '0) ? S_FIX : S_ITER;
        end
      end
      S_ITER:  if (cnt == CNT_W'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Iteration counter, loaded on acceptance and counted down in ITER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (accept)          cnt <= CNT_W'(WIDTH);
    else if (state == S_ITER) cnt <= cnt - CNT_W'(1);
  end

  // One iteration step: shift-add multiply (LSB first) or restoring divide (MSB first).
  always_comb begin
    mul_sum   = p[2*WIDTH:WIDTH] + opnd;
    div_trial = {1'b0, p[2*WIDTH-1:WIDTH-1]} - {1'b0, opnd};
    if (is_div) begin
      if (div_trial[WIDTH+1]) p_step = {p[2*WIDTH-1:0], 1'b0};
      else                    p_step = {div_trial[WIDTH:0], p[WIDTH-2:0], 1'b1};
    end else begin
      if (p[0]) p_step = {1'b0, mul_sum, p[WIDTH-1:1]};
      else      p_step = {1'b0, p[2*WIDTH:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod = res_neg ? cneg2(p[2*WIDTH-1:0]) : p[2*WIDTH-1:0];
    quo  = res_neg ? cneg(p[WIDTH-1:0]) : p[WIDTH-1:0];
    rem  = rem_neg ? cneg(p[2*WIDTH-1:WIDTH]) : p[2*WIDTH-1:WIDTH];
  end

  // Operand capture on acceptance, then one step per ITER cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div     <= (control == CTRL_DIV);
      div_zero_q <= (control == CTRL_DIV) && (b == '0);
      res_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      rem_neg    <= a[WIDTH-1];
      opnd       <= mag(b);
      if (control == CTRL_DIV && b == '0) p <= {{(WIDTH+1){1'b0}}, a};
      else                                p <= {{WIDTH{1'b0}}, mag(a)};
    end else if (state == S_ITER) begin
      p <= p_step;
    end
  end

  // Registered status outputs and the HI/LO pair (results and mthi/mtlo).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      busy        <= (state_nx != S_IDLE);
      done        <= (state == S_FIX);
      div_by_zero <= (state == S_FIX) && div_zero_q;
      if (state == S_FIX) begin
        if (div_zero_q) begin
          hi <= p[WIDTH-1:0];
          lo <= '1;
        end else if (is_div) begin
          hi <= rem;
          lo <= quo;
        end else begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
      end else if (state == S_IDLE && !accept) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, random
// operations against an arithmetic reference model, and hand sequences for
// mthi/mtlo, ignored starts and mid-operation reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  control;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(32), .CONTROL_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control(control),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int elat);
    longint sa, sb, pr, q, r;
    sa = $signed(x);
    sb = $signed(y);
    edz = 1'b0;
    if (c == 4'd10) begin
      pr = sa * sb;
      eh = pr[63:32];
      el = pr[31:0];
      elat = 33;
    end else if (sb == 0) begin
      eh = x;
      el = 32'hFFFFFFFF;
      edz = 1'b1;
      elat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0];
      el = q[31:0];
      elat = 33;
    end
  endfunction

  // Waits (bounded) for done; reports latency in cycles after the accept edge.
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    @(negedge clk);
    for (int k = 1; k <= 80; k++) begin
      if (busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input bit b2b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output int lat, output int bcnt);
    if (!b2b) @(negedge clk);
    start = 1'b1; control = c; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; control = 4'd0;
    wait_done(lat, bcnt);
    rh = hi; rl = lo; rdz = div_by_zero;
  endtask

  vec_t        tbl[13];
  logic [31:0] rh, rl, eh, el;
  logic        rdz, edz;
  int          lat, bcnt, elat, ndone;
  logic [31:0] ra, rb;
  logic [3:0]  rc;

  initial begin
    rst_n = 1'b0; start = 1'b0; control = 4'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    tbl[0]  = '{4'd10, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[1]  = '{4'd11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[2]  = '{4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    tbl[3]  = '{4'd11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
    tbl[4]  = '{4'd10, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    tbl[5]  = '{4'd11, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
    tbl[6]  = '{4'd10, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    tbl[7]  = '{4'd11, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, 1};
    tbl[8]  = '{4'd10, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 33};
    tbl[9]  = '{4'd11, 32'h80000000, 32'd1,        32'h00000000, 32'h80000000, 1'b0, 33};
    tbl[10] = '{4'd11, 32'd7,        32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    tbl[11] = '{4'd11, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000002, 1'b0, 33};
    tbl[12] = '{4'd10, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    rst_n = 1'b1;

    // Directed table, issued back-to-back from the done cycle
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].ctrl, tbl[i].a, tbl[i].b, i > 0, rh, rl, rdz, lat, bcnt);
      check($sformatf("tbl%0d hi", i), rh, tbl[i].hi);
      check($sformatf("tbl%0d lo", i), rl, tbl[i].lo);
      check($sformatf("tbl%0d dbz", i), rdz, tbl[i].dz);
      check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d busy cycles", i), bcnt, tbl[i].lat);
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? 4'd10 : 4'd11;
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = $urandom_range(1, 20);
        3:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      model(rc, ra, rb, eh, el, edz, elat);
      run_op(rc, ra, rb, $urandom_range(0, 1) == 1, rh, rl, rdz, lat, bcnt);
      check($sformatf("rnd%0d c=%0d a=%h b=%h hi", i, rc, ra, rb), rh, eh);
      check($sformatf("rnd%0d c=%0d a=%h b=%h lo", i, rc, ra, rb), rl, el);
      check($sformatf("rnd%0d dbz", i), rdz, edz);
      check($sformatf("rnd%0d latency", i), lat, elat);
    end

    // done / div_by_zero are single-cycle pulses
    run_op(4'd11, 32'd5, 32'd0, 1'b0, rh, rl, rdz, lat, bcnt);
    check("dz pulse latency", lat, 1);
    @(negedge clk);
    check("done one cycle", done, 0);
    check("dbz one cycle", div_by_zero, 0);

    // Unknown control code with start is ignored
    @(negedge clk);
    start = 1'b1; control = 4'd3; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("bad ctrl busy", busy, 0);
    check("bad ctrl hi", hi, 32'd5);

    // mthi/mtlo in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi+mtlo hi", hi, 32'h55);
    check("mthi+mtlo lo", lo, 32'h55);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo kept", lo, 32'h55);

    // mtlo during busy is dropped
    start = 1'b1; control = 4'd10; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    lo_we = 1'b0;
    check("busy mtlo lo", lo, 32'h55);
    wait_done(lat, bcnt);
    check("busy mtlo done seen", lat > 0, 1);
    check("busy mtlo result lo", lo, 32'd6);
    check("busy mtlo result hi", hi, 32'd0);

    // start with mtlo in the same cycle: start wins
    @(negedge clk);
    start = 1'b1; control = 4'd11; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'hBEEF;
    @(posedge clk);
    #1;
    start = 1'b0; lo_we = 1'b0;
    check("start+mtlo lo dropped", lo, 32'd6);
    check("start+mtlo busy", busy, 1);
    wait_done(lat, bcnt);
    check("start+mtlo latency", lat, 33);
    check("start+mtlo lo", lo, 32'd3);
    check("start+mtlo hi", hi, 32'd0);

    // Second start while busy is ignored, not queued
    @(negedge clk);
    start = 1'b1; control = 4'd10; a = 32'h7FFFFFFF; b = 32'h7FFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 10) begin start = 1'b1; control = 4'd11; a = 32'd9; b = 32'd3; end
      if (k == 11) start = 1'b0;
      if (done) ndone++;
    end
    check("ignored start done count", ndone, 1);
    check("ignored start hi", hi, 32'h3FFFFFFF);
    check("ignored start lo", lo, 32'h00000001);

    // Reset mid-operation aborts and clears
    hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    hi_we = 1'b0;
    start = 1'b1; control = 4'd10; a = 32'd7; b = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst dbz", div_by_zero, 0);
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("post rst no done", ndone, 0);
    check("post rst hi", hi, 0);
    run_op(4'd10, 32'd7, 32'hFFFFFFFD, 1'b0, rh, rl, rdz, lat, bcnt);
    check("post rst op hi", rh, 32'hFFFFFFFF);
    check("post rst op lo", rl, 32'hFFFFFFEB);
    check("post rst op latency", lat, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
